pipe_skid_reg_64: RTL and testbench

//  Elastic 64-bit pipeline stage register with valid/ready handshake, 2-entry skid buffer and flush.

---
 rtl/pipe_skid_reg_64_if.sv | 22 ++
 rtl/pipe_skid_reg_64.sv | 99 +++++++++
 tb/tb_pipe_skid_reg_64.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_64_if.sv
// Valid/ready handshake bundle for the elastic pipeline stage: upstream side (in_*) and downstream side (out_*).
// The stage itself uses the slave view; the neighbouring stages (or a bench) use the master view.
interface pipe_skid_reg_64_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/pipe_skid_reg_64.sv
// Elastic pipeline register with a 2-entry skid buffer, flush and a saturating stall counter.
// Every output decodes from registers only, so ready never ripples combinationally back upstream.
module pipe_skid_reg_64 #(
    parameter int WIDTH     = 64,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_skid_reg_64_if.slave    bus,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [WIDTH-1:0]     main_reg, main_next;
    logic [WIDTH-1:0]     skid_reg, skid_next;
    logic [CNT_WIDTH-1:0] stall_cnt_reg, stall_cnt_next;

    logic out_valid_int;
    logic in_ready_int;
    logic in_fire;
    logic out_fire;

    assign out_valid_int = (state_reg != EMPTY);
    assign in_ready_int  = (state_reg != FULL);
    assign in_fire       = bus.in_valid & in_ready_int;
    assign out_fire      = out_valid_int & bus.out_ready;

    assign bus.out_valid = out_valid_int;
    assign bus.in_ready  = in_ready_int;
    assign bus.out_data  = main_reg;
    assign occupancy     = state_reg;
    assign stall_cnt     = stall_cnt_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    main_next  = bus.in_data;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_next = bus.in_data;
                end else if (in_fire) begin
                    state_next = FULL;
                    skid_next  = bus.in_data;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_next = ONE;
                    main_next  = skid_reg;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Data regs may pick up a squashed payload here; out_valid=0 hides it.
        if (flush) begin
            state_next = EMPTY;
        end
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (out_valid_int && !bus.out_ready && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= EMPTY;
            main_reg      <= '0;
            skid_reg      <= '0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_reg      <= main_next;
            skid_reg      <= skid_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg_64.sv
// Directed bench for pipe_skid_reg_64: stimulus pushes hand-computed expected payloads into a queue,
// a negedge monitor pops and compares on every out_fire; state/status checks run inline.
module tb_pipe_skid_reg_64;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [63:0] exp_q[$];

    pipe_skid_reg_64_if #(.WIDTH(64)) bus ();

    pipe_skid_reg_64 #(.WIDTH(64), .CNT_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("check %s got=%0h required=%0h ok", name, act, exp);
        end else begin
            $display("FAIL %s got=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_fire must deliver the oldest outstanding expected payload.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            logic [63:0] e;
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop_unexpected got=%0h required=no_output", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data === e) begin
                    pass_cnt++;
                    $display("pop got=%0h required=%0h ok", bus.out_data, e);
                end else begin
                    $display("FAIL pop_data got=%0h required=%0h", bus.out_data, e);
                end
            end
        end
    end

    initial begin
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values are visible before any clock edge.
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_occupancy", 64'(occupancy),     64'd0);
        check("rst_stall_cnt", 64'(stall_cnt),     64'd0);
        check("rst_out_data",  bus.out_data,       64'd0);
        step();
        step();
        reset = 1'b1;

        // Passthrough: one-cycle latency, occupancy stays 1.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            bus.in_data = 64'(i);
            exp_q.push_back(64'(i));
            step();
            check("pass_occupancy", 64'(occupancy), 64'd1);
        end
        bus.in_valid = 1'b0;
        step();
        check("pass_drained", 64'(occupancy), 64'd0);
        check("pass_stall_cnt", 64'(stall_cnt), 64'd0);

        // Backpressure: fill both entries, hold, then drain in order.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hA;
        exp_q.push_back(64'hA);
        step();
        bus.in_data = 64'hB;
        exp_q.push_back(64'hB);
        step();
        bus.in_valid = 1'b0;
        check("bp_occupancy", 64'(occupancy),    64'd2);
        check("bp_in_ready",  64'(bus.in_ready), 64'd0);
        check("bp_out_data",  bus.out_data,      64'hA);
        check("bp_stall_1",   64'(stall_cnt),    64'd1);
        step();
        step();
        check("bp_hold_data", bus.out_data,   64'hA);
        check("bp_stall_3",   64'(stall_cnt), 64'd3);
        bus.out_ready = 1'b1;
        step();
        check("bp_pop1_in_ready",  64'(bus.in_ready), 64'd1);
        check("bp_pop1_occupancy", 64'(occupancy),    64'd1);
        check("bp_pop1_out_data",  bus.out_data,      64'hB);
        step();
        check("bp_empty", 64'(bus.out_valid), 64'd0);

        // Simultaneous in_fire and out_fire while holding one entry.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h5;
        exp_q.push_back(64'h5);
        step();
        bus.in_data   = 64'h6;
        bus.out_ready = 1'b1;
        exp_q.push_back(64'h6);
        step();
        check("sim_occupancy", 64'(occupancy), 64'd1);
        check("sim_out_data",  bus.out_data,   64'h6);
        bus.in_valid = 1'b0;
        step();
        check("sim_stall_cnt", 64'(stall_cnt), 64'd3);

        // Flush from FULL; squashed payloads are never pushed as expected.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'hA;
        step();
        bus.in_data = 64'hB;
        step();
        bus.in_data = 64'hC;
        flush       = 1'b1;
        step();
        check("flush_occupancy", 64'(occupancy),     64'd0);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        check("flush_stall_cnt", 64'(stall_cnt),     64'd5);
        bus.in_data = 64'hE;
        step();
        check("flush_held_occ", 64'(occupancy), 64'd0);
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_data   = 64'hD;
        exp_q.push_back(64'hD);
        step();
        bus.in_valid = 1'b0;
        step();
        check("flush_after_empty", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset while FULL.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h11;
        step();
        bus.in_data = 64'h22;
        step();
        bus.in_valid = 1'b0;
        check("mid_full_occ", 64'(occupancy), 64'd2);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("mid_rst_occupancy", 64'(occupancy),     64'd0);
        check("mid_rst_stall_cnt", 64'(stall_cnt),     64'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 64'h44;
        step();
        check("mid_rst_no_capture", 64'(occupancy), 64'd0);
        reset         = 1'b1;
        bus.in_data   = 64'h33;
        bus.out_ready = 1'b1;
        exp_q.push_back(64'h33);
        step();
        bus.in_valid = 1'b0;
        step();

        // Stall counter saturation at 15 for a 4-bit counter.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 64'h77;
        exp_q.push_back(64'h77);
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat_stall_cnt", 64'(stall_cnt), 64'd15);
        step();
        check("sat_hold", 64'(stall_cnt), 64'd15);
        bus.out_ready = 1'b1;
        step();
        step();
        check("end_occupancy", 64'(occupancy),   64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
